// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - round-robin arbiter sharing one smart_ram port between NUM_REQ requesters
// Optional WAIT-state timeout enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_access_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ-1:0]               req_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_offset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_in,
    output logic [NUM_REQ-1:0]               req_busy,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_out,
    output logic                             mem_wr,
    output logic                             mem_rd,
    output logic [ADDR_WIDTH-1:0]            mem_offset,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    input  logic                             mem_available,
    input  logic                             mem_write_finish,
    input  logic                             mem_read_finish,
    input  logic [DATA_WIDTH-1:0]            mem_data_out,
    output logic [NUM_REQ-1:0]               timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("sram_access_arbiter: NUM_REQ must be 2..4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("sram_access_arbiter: TIMEOUT_CYCLES must be 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_offset_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
    assign req_offset_a = req_offset;
    assign req_data_a   = req_data_in;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   grant_q, grant_d;
    logic [IDX_W-1:0]                   last_q, last_d;
    logic [NUM_REQ-1:0]                 slot_valid_q, slot_valid_d;
    logic [NUM_REQ-1:0]                 slot_wr_q, slot_wr_d;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] slot_offset_q, slot_offset_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slot_data_q, slot_data_d;
    logic                               mem_wr_q, mem_wr_d;
    logic                               mem_rd_q, mem_rd_d;
    logic [ADDR_WIDTH-1:0]              mem_offset_q, mem_offset_d;
    logic [DATA_WIDTH-1:0]              mem_data_in_q, mem_data_in_d;
    logic [NUM_REQ-1:0]                 req_done_q, req_done_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_out_q, data_out_d;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic [7:0]                         wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]                 timeout_err_q, timeout_err_d;
`endif

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             finish_hit;
    int               cand;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        slot_valid_d  = slot_valid_q;
        slot_wr_d     = slot_wr_q;
        slot_offset_d = slot_offset_q;
        slot_data_d   = slot_data_q;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        mem_offset_d  = mem_offset_q;
        mem_data_in_d = mem_data_in_q;
        req_done_d    = '0;
        data_out_d    = data_out_q;
`ifdef SRAM_ARB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        finish_hit = slot_wr_q[grant_q] ? mem_write_finish : mem_read_finish;

        // Search starts one past the last grant so every pending slot gets a turn.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!pick_found && slot_valid_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end

        // A write wins over a simultaneous read; busy slots ignore new pulses.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!slot_valid_q[i] && (req_wr[i] || req_rd[i])) begin
                slot_valid_d[i]  = 1'b1;
                slot_wr_d[i]     = req_wr[i];
                slot_offset_d[i] = req_offset_a[i];
                slot_data_d[i]   = req_data_a[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found && mem_available) begin
                    grant_d       = pick_idx;
                    mem_wr_d      = slot_wr_q[pick_idx];
                    mem_rd_d      = !slot_wr_q[pick_idx];
                    mem_offset_d  = slot_offset_q[pick_idx];
                    mem_data_in_d = slot_data_q[pick_idx];
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SRAM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (finish_hit) begin
                    req_done_d[grant_q] = 1'b1;
                    if (!slot_wr_q[grant_q]) begin
                        data_out_d[grant_q] = mem_data_out;
                    end
                    state_d = S_RESP;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    req_done_d[grant_q]    = 1'b1;
                    timeout_err_d[grant_q] = 1'b1;
                    state_d                = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                slot_valid_d[grant_q] = 1'b0;
                last_d                = grant_q;
                state_d               = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            last_q        <= IDX_W'(NUM_REQ - 1);
            slot_valid_q  <= '0;
            slot_wr_q     <= '0;
            slot_offset_q <= '0;
            slot_data_q   <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_offset_q  <= '0;
            mem_data_in_q <= '0;
            req_done_q    <= '0;
            data_out_q    <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            slot_valid_q  <= slot_valid_d;
            slot_wr_q     <= slot_wr_d;
            slot_offset_q <= slot_offset_d;
            slot_data_q   <= slot_data_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            mem_offset_q  <= mem_offset_d;
            mem_data_in_q <= mem_data_in_d;
            req_done_q    <= req_done_d;
            data_out_q    <= data_out_d;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign req_busy     = slot_valid_q;
    assign req_done     = req_done_q;
    assign req_data_out = data_out_q;
    assign mem_wr       = mem_wr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_offset   = mem_offset_q;
    assign mem_data_in  = mem_data_in_q;
`ifdef SRAM_ARB_TIMEOUT_EN
    assign timeout_err  = timeout_err_q;
`else
    assign timeout_err  = '0;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter with a smart_ram model
module tb_sram_access_arbiter;

    localparam int NR = 2;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int MODEL_LAT = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_wr, req_rd;
    logic [NR*AW-1:0]    req_offset;
    logic [NR*DW-1:0]    req_data_in;
    logic [NR-1:0]       req_busy, req_done;
    logic [NR*DW-1:0]    req_data_out;
    logic                mem_wr, mem_rd;
    logic [AW-1:0]       mem_offset;
    logic [DW-1:0]       mem_data_in;
    logic                mem_available;
    logic                mem_write_finish, mem_read_finish;
    logic [DW-1:0]       mem_data_out;
    logic [NR-1:0]       timeout_err;

    sram_access_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rd(req_rd), .req_offset(req_offset), .req_data_in(req_data_in),
        .req_busy(req_busy), .req_done(req_done), .req_data_out(req_data_out),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_offset(mem_offset), .mem_data_in(mem_data_in),
        .mem_available(mem_available), .mem_write_finish(mem_write_finish),
        .mem_read_finish(mem_read_finish), .mem_data_out(mem_data_out),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          wr;
        logic [12:0] off;
        logic [15:0] data;
    } iss_t;

    typedef struct {
        int          idx;
        bit          rd;
        logic [15:0] data;
        bit          to;
    } done_t;

    iss_t        iss_q[$];
    done_t       done_q[$];
    logic [15:0] model_mem[logic [12:0]];
    bit          model_hang = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // smart_ram stand-in: finish arrives MODEL_LAT cycles after the strobe cycle
    initial begin : model
        logic        op;
        logic [12:0] off;
        logic [15:0] d;
        mem_write_finish = 1'b0;
        mem_read_finish  = 1'b0;
        mem_data_out     = '0;
        forever begin
            @(negedge clk);
            if (mem_wr || mem_rd) begin
                op  = mem_wr;
                off = mem_offset;
                d   = mem_data_in;
                repeat (MODEL_LAT) @(negedge clk);
                if (!model_hang) begin
                    if (op) begin
                        model_mem[off]   = d;
                        mem_write_finish = 1'b1;
                    end else begin
                        mem_data_out    = model_mem.exists(off) ? model_mem[off] : 16'h0;
                        mem_read_finish = 1'b1;
                    end
                    @(negedge clk);
                    mem_write_finish = 1'b0;
                    mem_read_finish  = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        iss_t  ei;
        done_t ed;
        forever begin
            @(negedge clk);
            if (mem_wr || mem_rd) begin
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", iss_q.size(), 1);
                end else begin
                    ei = iss_q.pop_front();
                    check("issue_wr", mem_wr, ei.wr);
                    check("issue_rd", mem_rd, !ei.wr);
                    check("issue_offset", mem_offset, ei.off);
                    if (ei.wr) check("issue_data", mem_data_in, ei.data);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_done[i]) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", done_q.size(), 1);
                    end else begin
                        ed = done_q.pop_front();
                        check("done_idx", i, ed.idx);
                        if (ed.rd) check("done_rdata", req_data_out[i*DW +: DW], ed.data);
                        check("done_timeout_err", timeout_err[i], ed.to);
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input bit wr, input bit rd, input logic [12:0] off,
                           input logic [15:0] d);
        req_wr[i] = wr;
        req_rd[i] = rd;
        req_offset[i*AW +: AW] = off;
        req_data_in[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        req_wr[i] = 1'b0;
        req_rd[i] = 1'b0;
    endtask

    task automatic pulse(input int i, input bit wr, input bit rd, input logic [12:0] off,
                         input logic [15:0] d);
        set_req(i, wr, rd, off, d);
        @(negedge clk);
        clr_req(i);
    endtask

    task automatic wait_quiet();
        int c;
        c = 0;
        while ((req_busy != '0 || done_q.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("quiet_pending_done", done_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_strobes", {mem_wr, mem_rd}, 0);
        check("rst_mem_offset", mem_offset, 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_req_busy", req_busy, 0);
        check("rst_req_done", req_done, 0);
        check("rst_req_data_out", req_data_out, 0);
        check("rst_timeout_err", timeout_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs();
    endtask

    task automatic driver(input int i);
        int c;
        for (int k = 0; k < 4; k++) begin
            if (i == 0) set_req(0, 1'b1, 1'b0, 13'(256 + k), 16'(4096 + k));
            else        set_req(1, 1'b0, 1'b1, 13'(256 + k), 16'h0);
            @(negedge clk);
            clr_req(i);
            c = 0;
            while (!req_done[i] && c < 100) begin
                @(negedge clk);
                c++;
            end
            if (c >= 100) check("driver_done_timeout", c, 0);
            @(negedge clk);
        end
    endtask

    initial begin : stim
        int cyc;
        int cnt;
        rst           = 1'b0;
        req_wr        = '0;
        req_rd        = '0;
        req_offset    = '0;
        req_data_in   = '0;
        mem_available = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_reset_outputs();
        @(negedge clk);

        // single write with cycle-exact latency
        iss_q.push_back('{0, 1'b1, 13'h000, 16'h1234});
        done_q.push_back('{0, 1'b0, 16'h0, 1'b0});
        set_req(0, 1'b1, 1'b0, 13'h000, 16'h1234);
        @(negedge clk);
        clr_req(0);
        check("w_busy_c1", req_busy[0], 1);
        check("w_no_strobe_c1", mem_wr, 0);
        @(negedge clk);
        check("w_strobe_c2", mem_wr, 1);
        check("w_data_c2", mem_data_in, 16'h1234);
        cyc = 2;
        cnt = 0;
        while (!req_done[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!req_done[0] && (mem_wr || !req_busy[0])) cnt++;
        end
        check("w_done_cycle", cyc, 6);
        check("w_busy_and_no_restrobe", cnt, 0);
        @(negedge clk);
        check("w_done_single_pulse", req_done[0], 0);
        check("w_busy_cleared", req_busy[0], 0);

        // read on requester 1
        model_mem[13'h010] = 16'hBEEF;
        iss_q.push_back('{1, 1'b0, 13'h010, 16'h0});
        done_q.push_back('{1, 1'b1, 16'hBEEF, 1'b0});
        pulse(1, 1'b0, 1'b1, 13'h010, 16'h0);
        wait_quiet();
        check("r_data_held", req_data_out[DW +: DW], 16'hBEEF);
        check("r_other_unchanged", req_data_out[0 +: DW], 16'h0);

        // contention from reset, then both requesters kept pending
        do_reset();
        for (int k = 0; k < 4; k++) begin
            iss_q.push_back('{0, 1'b1, 13'(256 + k), 16'(4096 + k)});
            iss_q.push_back('{1, 1'b0, 13'(256 + k), 16'h0});
            done_q.push_back('{0, 1'b0, 16'h0, 1'b0});
            done_q.push_back('{1, 1'b1, 16'(4096 + k), 1'b0});
        end
        fork
            driver(0);
            driver(1);
        join
        wait_quiet();
        check("contention_all_issued", iss_q.size(), 0);

        // ignored requests: wr+rd together, then re-pulses while busy
        iss_q.push_back('{0, 1'b1, 13'h030, 16'h7777});
        done_q.push_back('{0, 1'b0, 16'h0, 1'b0});
        set_req(0, 1'b1, 1'b1, 13'h030, 16'h7777);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 13'h031, 16'h8888);
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 13'h032, 16'h9999);
        @(negedge clk);
        clr_req(0);
        wait_quiet();
        iss_q.push_back('{1, 1'b0, 13'h030, 16'h0});
        done_q.push_back('{1, 1'b1, 16'h7777, 1'b0});
        pulse(1, 1'b0, 1'b1, 13'h030, 16'h0);
        wait_quiet();

        // mem_available held low
        mem_available = 1'b0;
        iss_q.push_back('{0, 1'b1, 13'h040, 16'h4444});
        done_q.push_back('{0, 1'b0, 16'h0, 1'b0});
        pulse(0, 1'b1, 1'b0, 13'h040, 16'h4444);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_wr || mem_rd) cnt++;
            @(negedge clk);
        end
        check("avail_low_no_strobe", cnt, 0);
        mem_available = 1'b1;
        @(negedge clk);
        check("avail_issue_next_cycle", mem_wr, 1);
        wait_quiet();

`ifdef SRAM_ARB_TIMEOUT_EN
        model_hang = 1'b1;
        iss_q.push_back('{0, 1'b1, 13'h050, 16'h5555});
        done_q.push_back('{0, 1'b0, 16'h0, 1'b1});
        pulse(0, 1'b1, 1'b0, 13'h050, 16'h5555);
        cyc = 1;
        while (!req_done[0] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("to_done_cycle", cyc, 7);
        check("to_err_set", timeout_err, 2'b01);
        wait_quiet();
        check("to_err_sticky", timeout_err[0], 1);
`endif

        // reset in the middle of WAIT
        model_hang = 1'b1;
        iss_q.push_back('{0, 1'b1, 13'h060, 16'h6666});
        pulse(0, 1'b1, 1'b0, 13'h060, 16'h6666);
        repeat (2) @(negedge clk);
        check("rst_wait_busy", req_busy[0], 1);
        do_reset();
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_done != '0) cnt++;
        end
        check("rst_wait_no_done", cnt, 0);
        model_hang = 1'b0;

        // recovery after abandoned transaction
        iss_q.push_back('{1, 1'b1, 13'h070, 16'hC0DE});
        done_q.push_back('{1, 1'b0, 16'h0, 1'b0});
        pulse(1, 1'b1, 1'b0, 13'h070, 16'hC0DE);
        wait_quiet();

        check("final_issue_queue_empty", iss_q.size(), 0);
        check("final_done_queue_empty", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares one smart_ram delay-line port (13-bit offset, 16-bit data) between NUM_REQ effect engines, e.g. echo and reverb taps.
- Each requester issues single-cycle read or write pulses. The arbiter latches them, grants round-robin, sequences the smart_ram handshake (wr/rd pulse, then write_finish/read_finish), and returns a per-requester done pulse plus read data.
- Sits between the effect datapaths and smart_ram in the DE1 top level.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 13, offset width; matches smart_ram
DATA_WIDTH, 16, sample width
TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with SRAM_ARB_TIMEOUT_EN; 2..255)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
req_wr  in  NUM_REQ  per-requester write pulse
req_rd  in  NUM_REQ  per-requester read pulse
req_offset  in  NUM_REQ*ADDR_WIDTH  flattened offsets; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data_in  in  NUM_REQ*DATA_WIDTH  flattened write data
req_busy  out  NUM_REQ  slot i holds an unfinished request
req_done  out  NUM_REQ  one-cycle completion pulse
req_data_out  out  NUM_REQ*DATA_WIDTH  per-requester read result, held until the next read completes
mem_wr  out  1  to smart_ram wr
mem_rd  out  1  to smart_ram rd
mem_offset  out  ADDR_WIDTH  to smart_ram offset
mem_data_in  out  DATA_WIDTH  to smart_ram data_in
mem_available  in  1  from smart_ram available
mem_write_finish  in  1  from smart_ram write_finish
mem_read_finish  in  1  from smart_ram read_finish
mem_data_out  in  DATA_WIDTH  from smart_ram data_out
timeout_err  out  NUM_REQ  sticky timeout flag per requester

Behaviour:
- Reset (rst==0 at a rising edge): all outputs 0, all slots empty, FSM in IDLE, round-robin pointer set so requester 0 has first priority. Reset mid-transaction abandons the transaction without a done pulse; smart_ram is reset separately.
- Slot capture: on an edge where req_busy[i]==0 and (req_wr[i] or req_rd[i]) is high, latch op, offset and data. req_busy[i] goes high the next cycle.
  - wr and rd together: the write is latched and the read is dropped.
  - Pulses while req_busy[i]==1 are ignored (no queueing).
- FSM states:
  - IDLE: if any slot is pending and mem_available==1, grant the first pending slot after the last grant (round-robin, wrap NUM_REQ-1 -> 0). Go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): mem_wr or mem_rd = 1 per the latched op; mem_offset and mem_data_in driven from the granted slot. Go to WAIT.
  - WAIT: mem_offset and mem_data_in stay stable and strobes are 0.
    - On mem_write_finish (write op) or mem_read_finish (read op), go to RESP.
    - For reads, capture mem_data_out into req_data_out[g] in that same edge.
  - RESP (1 cycle): req_done[g]=1. Slot g is cleared, so req_busy[g]=0 from the next cycle. Update the round-robin pointer to g. Go to IDLE.
- Latency, idle arbiter with mem_available=1:
  - Request pulse at cycle 0; slot valid at cycle 1; ISSUE at cycle 2 with mem_* strobe high.
  - req_done goes high the cycle after the edge that samples finish.
  - Against smart_ram, a write completes with req_done at cycle 6.
- mem_*_finish outside WAIT is ignored. A finish of the wrong type in WAIT is ignored.
- A requester may re-request in the cycle after its req_done pulse. It still waits its round-robin turn.
- Fairness: with all slots continuously pending, grants rotate strictly 0,1,..,NUM_REQ-1. No requester waits more than NUM_REQ-1 transactions.
- Outputs mem_wr, mem_rd, mem_offset, mem_data_in, req_done and req_busy are all registered.

Optional Feature:
SRAM_ARB_TIMEOUT_EN
- Defined: an 8-bit counter counts WAIT cycles.
  - On reaching TIMEOUT_CYCLES without the expected finish, go to RESP anyway, pulsing req_done[g] and setting timeout_err[g] (sticky until reset).
  - A timed-out read leaves req_data_out[g] unchanged.
  - A finish arriving later, in IDLE, is ignored.
- Undefined: WAIT waits indefinitely, timeout_err is tied to 0, and no counter is synthesised.

Test Plan:
- Single write: req_wr[0]=1, offset 0x000, data 0x1234, with a smart_ram model -> mem_wr high only at cycle 2, mem_data_in=0x1234; req_done[0] single pulse; req_busy[0] high from cycle 1 until req_done.
- Read: req_rd[1], offset 0x010, model returns 0xBEEF on read_finish -> req_data_out[1]=0xBEEF held; req_done[1] single pulse; req_data_out[0] unchanged.
- Contention: req_wr[0] and req_rd[1] in the same cycle, after reset -> requester 0 served first, then 1. Repeated 8 times with both always pending -> grants alternate 0,1,0,1.
- Ignored requests: req_wr[0] pulsed again while req_busy[0]=1, and req_wr[0] with req_rd[0] together -> only one write issued; no mem_rd for requester 0.
- mem_available held 0 for 10 cycles with slot 0 pending -> no mem_wr or mem_rd; ISSUE occurs 1 cycle after available rises.
- Reset mid-WAIT: rst=0 for 1 cycle -> all outputs 0 next cycle, no req_done. With SRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4 and the model never finishing -> req_done[0] and timeout_err[0]=1 after 4 WAIT cycles.
